// File: rtl/refill_collector.sv
`timescale 1ns/1ps
// refill_collector: assembles memory return beats for the oldest outstanding
// MSHR entry into one cache line and hands it to the data accessor over a
// valid/ready handshake. `received` pulses on the handshake cycle so the miss
// handler can retire the entry.
// Optional build macro REFILL_BYPASS_EN adds a registered critical-word bypass
// port (byp_valid/byp_addr/byp_data), one cycle after each accepted beat.
module refill_collector #(
   parameter int WORD_W     = 32,
   parameter int LINE_WORDS = 4,
   parameter int LADDR_W    = 28
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         mshr_pending,
   input  logic [LADDR_W-1:0]           mshr_addr,
   input  logic                         mem_valid,
   input  logic [WORD_W-1:0]            mem_data,
   output logic                         mem_ready,
   output logic                         da_valid,
   input  logic                         da_ready,
   output logic [LADDR_W-1:0]           da_addr,
   output logic [WORD_W*LINE_WORDS-1:0] da_data,
   output logic                         received,
`ifdef REFILL_BYPASS_EN
   output logic                         byp_valid,
   output logic [LADDR_W+1:0]           byp_addr,
   output logic [WORD_W-1:0]            byp_data,
`endif
   output logic                         err_unexp
);

   localparam int CNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DELIVER = 2'd2
   } state_t;

   state_t                               state_q, state_d;
   logic [CNT_W-1:0]                     beat_cnt_q, beat_cnt_d;
   logic [LINE_WORDS-1:0][WORD_W-1:0]    line_q, line_d;
   logic [LADDR_W-1:0]                   addr_q, addr_d;
   logic                                 err_q, err_d;
   logic                                 accept_s;

   // Handshake decodes come from registered state only (no path from mem_valid to mem_ready).
   always_comb begin
      mem_ready = (state_q == ST_COLLECT);
      da_valid  = (state_q == ST_DELIVER);
      accept_s  = mem_valid & mem_ready;
      received  = da_valid & da_ready;
   end

   assign da_addr   = addr_q;
   assign da_data   = line_q;
   assign err_unexp = err_q;

   // Next-state logic: latch the entry address, fill word slots in order, hold line until taken.
   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      line_d     = line_q;
      addr_d     = addr_q;
      err_d      = err_q;
      case (state_q)
         ST_IDLE: begin
            if (mshr_pending) begin
               addr_d     = mshr_addr;
               beat_cnt_d = '0;
               state_d    = ST_COLLECT;
            end else begin
               state_d    = ST_IDLE;
            end
            // A beat with nothing being collected is never consumed, only flagged.
            if (mem_valid) begin
               err_d = 1'b1;
            end else begin
               err_d = err_q;
            end
         end
         ST_COLLECT: begin
            if (accept_s) begin
               line_d[beat_cnt_q] = mem_data;
               beat_cnt_d         = beat_cnt_q + CNT_W'(1);
               if (beat_cnt_q == CNT_W'(LINE_WORDS - 1)) begin
                  state_d = ST_DELIVER;
               end else begin
                  state_d = ST_COLLECT;
               end
            end else begin
               state_d = ST_COLLECT;
            end
         end
         ST_DELIVER: begin
            if (received) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DELIVER;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counter, line buffer, address and sticky error registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         beat_cnt_q <= '0;
         line_q     <= '0;
         addr_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         line_q     <= line_d;
         addr_q     <= addr_d;
         err_q      <= err_d;
      end
   end

`ifdef REFILL_BYPASS_EN
   logic                   byp_valid_q, byp_valid_d;
   logic [LADDR_W+1:0]     byp_addr_q, byp_addr_d;
   logic [WORD_W-1:0]      byp_data_q, byp_data_d;

   // Capture each accepted beat with its full word address for early forwarding.
   always_comb begin
      byp_valid_d = accept_s;
      byp_addr_d  = byp_addr_q;
      byp_data_d  = byp_data_q;
      if (accept_s) begin
         byp_addr_d = {addr_q, beat_cnt_q};
         byp_data_d = mem_data;
      end else begin
         byp_addr_d = byp_addr_q;
         byp_data_d = byp_data_q;
      end
   end

   // Bypass output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         byp_valid_q <= 1'b0;
         byp_addr_q  <= '0;
         byp_data_q  <= '0;
      end else begin
         byp_valid_q <= byp_valid_d;
         byp_addr_q  <= byp_addr_d;
         byp_data_q  <= byp_data_d;
      end
   end

   assign byp_valid = byp_valid_q;
   assign byp_addr  = byp_addr_q;
   assign byp_data  = byp_data_q;
`endif

endmodule

// File: tb/tb_refill_collector.sv
`timescale 1ns/1ps
// Self-checking bench for refill_collector: directed test-plan steps plus
// randomized refills, checked against a line-level reference model.
module tb_refill_collector;

   logic          clk = 1'b0;
   logic          resetn;
   logic          mshr_pending;
   logic [27:0]   mshr_addr;
   logic          mem_valid;
   logic [31:0]   mem_data;
   logic          mem_ready;
   logic          da_valid;
   logic          da_ready;
   logic [27:0]   da_addr;
   logic [127:0]  da_data;
   logic          received;
   logic          err_unexp;
`ifdef REFILL_BYPASS_EN
   logic          byp_valid;
   logic [29:0]   byp_addr;
   logic [31:0]   byp_data;
`endif

   int errors = 0;
   int checks = 0;
   logic err_exp = 1'b0;

   refill_collector #(.WORD_W(32), .LINE_WORDS(4), .LADDR_W(28)) dut (
      .clk(clk), .resetn(resetn),
      .mshr_pending(mshr_pending), .mshr_addr(mshr_addr),
      .mem_valid(mem_valid), .mem_data(mem_data), .mem_ready(mem_ready),
      .da_valid(da_valid), .da_ready(da_ready), .da_addr(da_addr), .da_data(da_data),
      .received(received),
`ifdef REFILL_BYPASS_EN
      .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data),
`endif
      .err_unexp(err_unexp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete refill of line a from IDLE; expected line built from the beats.
   task automatic refill(input logic [27:0] a,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3,
                         input int gap, input int stall, input logic hold_pend);
      logic [31:0]  w [4];
      logic [127:0] exp_line;
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
      for (int k = 0; k < 4; k++) exp_line[32*k +: 32] = w[k];
      // IDLE cycle (also the bubble after a previous delivery)
      mshr_pending = 1'b1; mshr_addr = a; mem_valid = 1'b0; da_ready = (stall == 0);
      @(negedge clk);
      chk("idle_mem_ready", {127'd0, mem_ready}, 128'd0);
      chk("idle_da_valid",  {127'd0, da_valid},  128'd0);
      chk("idle_received",  {127'd0, received},  128'd0);
      tick();
      for (int k = 0; k < 4; k++) begin
         for (int g = 0; g < gap; g++) begin
            mshr_pending = hold_pend ? 1'b1 : 1'($urandom);
            mshr_addr = 28'($urandom); mem_valid = 1'b0; mem_data = $urandom;
            @(negedge clk);
            chk("gap_mem_ready", {127'd0, mem_ready}, 128'd1);
            chk("gap_da_valid",  {127'd0, da_valid},  128'd0);
            tick();
         end
         mshr_pending = hold_pend ? 1'b1 : 1'($urandom);
         mshr_addr = 28'($urandom); mem_valid = 1'b1; mem_data = w[k];
         @(negedge clk);
         chk("beat_mem_ready", {127'd0, mem_ready}, 128'd1);
         chk("beat_da_valid",  {127'd0, da_valid},  128'd0);
         tick();
`ifdef REFILL_BYPASS_EN
         chk("byp_valid", {127'd0, byp_valid}, 128'd1);
         chk("byp_data",  {96'd0, byp_data},   {96'd0, w[k]});
         chk("byp_addr",  {98'd0, byp_addr},   {98'd0, a, 2'(k)});
`endif
      end
      mshr_pending = hold_pend;
      for (int s = 0; s < stall; s++) begin
         da_ready = 1'b0; mem_valid = 1'b1; mem_data = $urandom;
         @(negedge clk);
         chk("stall_da_valid",  {127'd0, da_valid},  128'd1);
         chk("stall_mem_ready", {127'd0, mem_ready}, 128'd0);
         chk("stall_received",  {127'd0, received},  128'd0);
         chk("stall_da_addr",   {100'd0, da_addr},   {100'd0, a});
         chk("stall_da_data",   da_data,             exp_line);
         tick();
      end
      da_ready = 1'b1; mem_valid = 1'b0;
      @(negedge clk);
      chk("dlv_da_valid",  {127'd0, da_valid},  128'd1);
      chk("dlv_received",  {127'd0, received},  128'd1);
      chk("dlv_da_addr",   {100'd0, da_addr},   {100'd0, a});
      chk("dlv_da_data",   da_data,             exp_line);
      chk("dlv_err_unexp", {127'd0, err_unexp}, {127'd0, err_exp});
      tick();
      da_ready = 1'b0;
   endtask

   initial begin
      resetn = 1'b0; mshr_pending = 1'b0; mshr_addr = '0;
      mem_valid = 1'b0; mem_data = '0; da_ready = 1'b0;
      #2;
      chk("rst_mem_ready", {127'd0, mem_ready}, 128'd0);
      chk("rst_da_valid",  {127'd0, da_valid},  128'd0);
      chk("rst_da_data",   da_data,             128'd0);
      chk("rst_da_addr",   {100'd0, da_addr},   128'd0);
      chk("rst_received",  {127'd0, received},  128'd0);
      chk("rst_err_unexp", {127'd0, err_unexp}, 128'd0);
      @(negedge clk); resetn = 1'b1; tick();

      // basic, gapped, backpressured
      refill(28'h0ABCDEF, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 0, 0, 1'b0);
      refill(28'h0ABCDEF, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 2, 0, 1'b0);
      refill(28'h0ABCDEF, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 0, 5, 1'b0);

      // back-to-back entries with mshr_pending held high
      refill(28'h0000010, $urandom, $urandom, $urandom, $urandom, 0, 0, 1'b1);
      refill(28'h0000011, $urandom, $urandom, $urandom, $urandom, 0, 0, 1'b0);

      // randomized refills
      for (int i = 0; i < 16; i++) begin
         refill(28'($urandom), $urandom, $urandom, $urandom, $urandom,
                $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      // reset in the middle of collection
      mshr_pending = 1'b1; mshr_addr = 28'h5555555; mem_valid = 1'b0;
      tick();
      mshr_pending = 1'b0;
      for (int b = 0; b < 2; b++) begin
         mem_valid = 1'b1; mem_data = $urandom;
         tick();
      end
      mem_valid = 1'b0;
      resetn = 1'b0;
      #1;
      chk("mid_rst_mem_ready", {127'd0, mem_ready}, 128'd0);
      chk("mid_rst_da_valid",  {127'd0, da_valid},  128'd0);
      chk("mid_rst_da_data",   da_data,             128'd0);
      chk("mid_rst_da_addr",   {100'd0, da_addr},   128'd0);
      chk("mid_rst_received",  {127'd0, received},  128'd0);
      err_exp = 1'b0;
      @(negedge clk); resetn = 1'b1; tick();
      refill(28'h0000020, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD, 0, 0, 1'b0);

      // unexpected beat while idle
      mshr_pending = 1'b0; mem_valid = 1'b1; mem_data = 32'hDEADBEEF;
      @(negedge clk);
      chk("unexp_mem_ready", {127'd0, mem_ready}, 128'd0);
      chk("unexp_err_before", {127'd0, err_unexp}, 128'd0);
      tick();
      err_exp = 1'b1;
      chk("unexp_err_set", {127'd0, err_unexp}, 128'd1);
      mem_valid = 1'b0;
      for (int j = 0; j < 3; j++) begin
         tick();
         chk("unexp_err_sticky", {127'd0, err_unexp}, 128'd1);
      end
      refill(28'($urandom), $urandom, $urandom, $urandom, $urandom, 1, 2, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
